// File: rtl/cz80_alu16_seq_if.sv
// rtl/cz80_alu16_seq_if.sv - request/response and ALU-drive bundle for the 16-bit arithmetic sequencer
interface cz80_alu16_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [7:0]  f_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [7:0]  alu_f;
  logic [7:0]  alu_q;
  logic [7:0]  alu_f_out;

  modport master (
    output start, op, opa, opb, f_in, alu_q, alu_f_out,
    input  busy, done, result, f_out,
    input  alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f
  );

  modport slave (
    input  start, op, opa, opb, f_in, alu_q, alu_f_out,
    output busy, done, result, f_out,
    output alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f
  );
endinterface

// File: rtl/cz80_alu16_seq.sv
// rtl/cz80_alu16_seq.sv - ADD/ADC/SBC/SUB 16-bit as two chained byte passes through cz80_alu
module cz80_alu16_seq (
  input logic              clk,
  input logic              reset,
  cz80_alu16_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [7:0]  opa_hi;
  logic [7:0]  opb_hi;
  logic [7:0]  res_lo;

  // Low pass: plain add/sub, carry-in only for ADC/SBC.
  function automatic logic [3:0] lo_alu_op(input logic [1:0] op);
    case (op)
      2'b00:   lo_alu_op = 4'd0;
      2'b01:   lo_alu_op = 4'd1;
      2'b10:   lo_alu_op = 4'd3;
      default: lo_alu_op = 4'd2;
    endcase
  endfunction

  // High pass always consumes the low-byte carry.
  function automatic logic [3:0] hi_alu_op(input logic [1:0] op);
    hi_alu_op = op[1] ? 4'd3 : 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      op_q            <= 2'b00;
      opa_hi          <= 8'h00;
      opb_hi          <= 8'h00;
      res_lo          <= 8'h00;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.result      <= 16'h0000;
      bus.f_out       <= 8'h00;
      bus.alu_op      <= 4'd0;
      bus.alu_arith16 <= 1'b0;
      bus.alu_z16     <= 1'b0;
      bus.alu_busa    <= 8'h00;
      bus.alu_busb    <= 8'h00;
      bus.alu_f       <= 8'h00;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state           <= LO;
            op_q            <= bus.op;
            opa_hi          <= bus.opa[15:8];
            opb_hi          <= bus.opb[15:8];
            bus.busy        <= 1'b1;
            bus.alu_op      <= lo_alu_op(bus.op);
            bus.alu_arith16 <= (bus.op == 2'b00);
            bus.alu_z16     <= 1'b0;
            bus.alu_busa    <= bus.opa[7:0];
            bus.alu_busb    <= bus.opb[7:0];
            bus.alu_f       <= bus.f_in;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        LO: begin
          state           <= HI;
          res_lo          <= bus.alu_q;
          bus.alu_op      <= hi_alu_op(op_q);
          bus.alu_z16     <= (op_q != 2'b00);
          bus.alu_busa    <= opa_hi;
          bus.alu_busb    <= opb_hi;
          // Low-pass flags feed the high pass as its carry/zero source.
          bus.alu_f       <= bus.alu_f_out;
        end
        HI: begin
          state           <= DONE;
          bus.result      <= {bus.alu_q, res_lo};
          bus.f_out       <= bus.alu_f_out;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          bus.alu_op      <= 4'd0;
          bus.alu_arith16 <= 1'b0;
          bus.alu_z16     <= 1'b0;
          bus.alu_busa    <= 8'h00;
          bus.alu_busb    <= 8'h00;
          bus.alu_f       <= 8'h00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cz80_alu16_seq.sv
// tb/tb_cz80_alu16_seq.sv - bench for cz80_alu16_seq with a behavioural 8-bit cz80_alu
module tb_cz80_alu16_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cz80_alu16_seq_if bus ();
  cz80_alu16_seq dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_checks = 0;
  int n_fail = 0;

  // Byte ALU: add/adc/sub/sbc with arith16 and z16 behaviour.
  function automatic logic [15:0] alu8(input logic [3:0] op, input logic a16, input logic z16,
                                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    logic       sub, cin, hc, c7, cv;
    logic [7:0] bb, q, fo;
    logic [4:0] lo;
    logic [3:0] mid;
    logic [1:0] top;
    sub = op[1];
    cin = sub ^ (~op[2] & op[0] & f[0]);
    bb  = b ^ {8{sub}};
    lo  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'd0, cin};
    hc  = lo[4];
    mid = {1'b0, a[6:4]} + {1'b0, bb[6:4]} + {3'd0, hc};
    c7  = mid[3];
    top = {1'b0, a[7]} + {1'b0, bb[7]} + {1'b0, c7};
    cv  = top[1];
    q   = {top[0], mid[2:0], lo[3:0]};
    fo  = f;
    fo[0] = cv ^ sub;
    fo[1] = sub;
    fo[2] = cv ^ c7;
    fo[3] = q[3];
    fo[4] = hc ^ sub;
    fo[5] = q[5];
    fo[6] = (q == 8'h00) ? (z16 ? f[6] : 1'b1) : 1'b0;
    fo[7] = q[7];
    if (a16) begin
      fo[7] = f[7];
      fo[6] = f[6];
      fo[2] = f[2];
    end
    return {q, fo};
  endfunction

  logic [15:0] alu_pair;
  always_comb begin
    alu_pair = alu8(bus.alu_op, bus.alu_arith16, bus.alu_z16, bus.alu_busa, bus.alu_busb, bus.alu_f);
    bus.alu_q     = alu_pair[15:8];
    bus.alu_f_out = alu_pair[7:0];
  end

  // Whole-word Z80 reference: returns {result, flags}.
  function automatic logic [23:0] ref16(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] f);
    logic        sub, cin, h, v;
    logic [16:0] r;
    logic [7:0]  fo;
    sub = op[1];
    cin = (op == 2'b01 || op == 2'b10) ? f[0] : 1'b0;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      h = ({1'b0, a[11:0]} + {1'b0, b[11:0]} + {12'd0, cin}) > 13'h0FFF;
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      h = {1'b0, a[11:0]} < ({1'b0, b[11:0]} + {12'd0, cin});
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end
    fo = {r[15], (r[15:0] == 16'h0000), r[13], h, r[11], v, sub, r[16]};
    if (op == 2'b00) begin
      fo[7] = f[7];
      fo[6] = f[6];
      fo[2] = f[2];
    end
    return {r[15:0], fo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    bus.f_in  = f;
  endtask

  // Called on the negedge where start is being presented.
  task automatic wait_done(input string name, input logic [15:0] exp_r, input logic [7:0] exp_f,
                           input logic [7:0] fmask);
    int lat;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, 3);
    check({name, " result"}, bus.result, exp_r);
    check({name, " f_out"}, bus.f_out & fmask, exp_f & fmask);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  f;
    logic [15:0] exp_r;
    logic [7:0]  exp_f;
  } vec_t;

  vec_t vecs[7];
  int   dones;
  logic [15:0] cap_r;
  logic [7:0]  cap_f;
  logic [23:0] exp;

  initial begin
    vecs[0] = '{2'b00, 16'h0FFF, 16'h0001, 8'hC5, 16'h1000, 8'hD4};
    vecs[1] = '{2'b10, 16'h1000, 16'h1000, 8'h00, 16'h0000, 8'h42};
    vecs[2] = '{2'b10, 16'h0001, 16'h0000, 8'h00, 16'h0001, 8'h02};
    vecs[3] = '{2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51};
    vecs[4] = '{2'b11, 16'h0000, 16'h0001, 8'h01, 16'hFFFF, 8'hBB};
    vecs[5] = '{2'b00, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h01};
    vecs[6] = '{2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opa   = 16'h0000;
    bus.opb   = 16'h0000;
    bus.f_in  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset result", bus.result, 0);
    check("reset f_out", bus.f_out, 0);
    check("reset alu drive", {bus.alu_op, bus.alu_arith16, bus.alu_z16, bus.alu_busa, bus.alu_busb, bus.alu_f}, 0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].f);
      wait_done($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_f, 8'hFF);
    end

    // ADC16: pass-by-pass ALU drive
    @(negedge clk);
    issue(2'b01, 16'hFFFF, 16'h0000, 8'h01);
    @(negedge clk);
    bus.start = 1'b0;
    bus.opa = 16'h1234;
    check("lo busy", bus.busy, 1);
    check("lo alu_op", bus.alu_op, 1);
    check("lo alu_f", bus.alu_f, 8'h01);
    check("lo alu_busa", bus.alu_busa, 8'hFF);
    check("lo alu_z16", bus.alu_z16, 0);
    @(negedge clk);
    check("hi alu_op", bus.alu_op, 1);
    check("hi alu_z16", bus.alu_z16, 1);
    check("hi alu_f", bus.alu_f, 8'h51);
    check("hi alu_busa", bus.alu_busa, 8'hFF);
    @(negedge clk);
    check("adc done", bus.done, 1);
    check("adc busy", bus.busy, 0);
    check("adc result", bus.result, 16'h0000);
    check("adc f_out", bus.f_out, 8'h51);
    check("done alu_op", bus.alu_op, 0);
    @(negedge clk);
    check("done pulse width", bus.done, 0);

    // start ignored while busy
    issue(2'b00, 16'h0FFF, 16'h0001, 8'hC5);
    @(negedge clk);
    issue(2'b11, 16'h1234, 16'h0034, 8'h00);
    @(negedge clk);
    issue(2'b10, 16'hAAAA, 16'h5555, 8'h01);
    dones = 0;
    cap_r = 16'h0;
    cap_f = 8'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        cap_r = bus.result;
        cap_f = bus.f_out;
      end
    end
    check("busy reject done count", dones, 1);
    check("busy reject result", cap_r, 16'h1000);
    check("busy reject f_out", cap_f, 8'hD4);

    // back-to-back: second start lands in the DONE cycle
    @(negedge clk);
    issue(2'b10, 16'h1000, 16'h1000, 8'h00);
    wait_done("b2b first", 16'h0000, 8'h42, 8'hFF);
    issue(2'b00, 16'h8000, 16'h8000, 8'h00);
    wait_done("b2b second", 16'h0000, 8'h01, 8'hFF);

    // reset during HI aborts
    @(negedge clk);
    issue(2'b11, 16'h0000, 16'h0001, 8'h00);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre-abort busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort result", bus.result, 0);
    check("abort f_out", bus.f_out, 0);
    check("abort alu drive", {bus.alu_op, bus.alu_arith16, bus.alu_z16, bus.alu_busa, bus.alu_busb, bus.alu_f}, 0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no done", dones, 0);

    for (int i = 0; i < 10000; i++) begin
      logic [1:0]  rop;
      logic [15:0] ra, rb;
      logic [7:0]  rf;
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rf  = 8'($urandom);
      exp = ref16(rop, ra, rb, rf);
      @(negedge clk);
      issue(rop, ra, rb, rf);
      wait_done($sformatf("rand%0d op%0d %h %h %h", i, rop, ra, rb, rf), exp[23:8], exp[7:0], 8'hD7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
